// File: rtl/inst_fetch_queue.sv
// Decoupled instruction-fetch queue: owns the fetch PC, buffers {pc, inst} pairs and
// hands them to decode over valid/ready. Optional zero-latency bypass: FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [31:0]              inst_adr,
   input  logic [31:0]              inst,
   input  logic                     fetch_en,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   output logic [31:0]              out_inst,
   output logic [31:0]              out_pc,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     state_dbg
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

   // Handshake: an entry transfers on a rising edge where out_valid and out_ready are
   // both high and redirect is low; out_valid never depends on out_ready.
   state_t          state;
   logic [31:0]     fetch_pc;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [31:0]     mem_inst [DEPTH];
   logic [31:0]     mem_pc   [DEPTH];

   logic has_entry;
   logic can_fetch;
   logic bypass_vis;
   logic bypass_take;
   logic fifo_pop;
   logic fifo_push;

   assign inst_adr  = fetch_pc;
   assign state_dbg = state;
   assign has_entry = (count != '0);
   assign can_fetch = (state == FETCH) & fetch_en & ~redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
   // Empty queue: present the memory word directly so decode sees it this cycle.
   assign bypass_vis = ~has_entry & can_fetch & ~rst;
`else
   assign bypass_vis = 1'b0;
`endif

   assign bypass_take = bypass_vis & out_ready;
   assign fifo_pop    = has_entry & out_ready & ~redirect;
   assign fifo_push   = can_fetch & ((count < CW'(DEPTH)) | fifo_pop) & ~bypass_take;

   always_comb begin
      out_valid = has_entry;
      out_inst  = 32'h0;
      out_pc    = 32'h0;
      if (has_entry) begin
         out_inst = mem_inst[rd_ptr];
         out_pc   = mem_pc[rd_ptr];
      end else if (bypass_vis) begin
         out_valid = 1'b1;
         out_inst  = inst;
         out_pc    = fetch_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (redirect) begin
         // State is kept: a redirect only flushes and retargets the fetch stream.
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         state <= fetch_en ? FETCH : HOLD;
         if (fifo_push | bypass_take) fetch_pc <= fetch_pc + 32'd4;
         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (fifo_push & ~fifo_pop)      count <= count + 1'b1;
         else if (fifo_pop & ~fifo_push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: it is only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (fifo_push & ~rst) begin
         mem_inst[wr_ptr] <= inst;
         mem_pc[wr_ptr]   <= fetch_pc;
      end
   end

endmodule
